// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a host loader port.
// CPU has priority; a starved host is forced through after STARVE_MAX waits.
module dmem_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_index,
    output logic [DW-1:0] mem_entry,
    input  logic [DW-1:0] mem_entry_out,
    output logic [3:0]    starve_cnt
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic force_host;
    logic rd_valid;
    logic rd_host;

    // Grant decision: CPU first unless the host has waited its limit.
    always_comb begin
        force_host = (starve_cnt == SMAX) && host_req;
        cpu_gnt    = cpu_req && !force_host;
        host_gnt   = host_req && (!cpu_req || force_host);
    end

    // Route the granted port onto the RAM; writes are blocked during reset.
    always_comb begin
        mem_wr_en = 1'b0;
        mem_index = '0;
        mem_entry = '0;
        unique case (1'b1)
            cpu_gnt: begin
                mem_wr_en = cpu_we;
                mem_index = cpu_addr;
                mem_entry = cpu_wdata;
            end
            host_gnt: begin
                mem_wr_en = host_we;
                mem_index = host_addr;
                mem_entry = host_wdata;
            end
            default: ;
        endcase
        if (!rstn) mem_wr_en = 1'b0;
    end

    // Host wait counter: cleared on grant or withdraw, saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (host_gnt) begin
            starve_cnt <= '0;
        end else if (host_req) begin
            if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Remember which port owns the load data arriving next cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_valid <= 1'b0;
            rd_host  <= 1'b0;
        end else begin
            rd_valid <= (cpu_gnt && !cpu_we) || (host_gnt && !host_we);
            rd_host  <= host_gnt;
        end
    end

    // Return RAM data only to the owning port; the other sees zeros.
    always_comb begin
        cpu_rvalid  = rd_valid && !rd_host;
        host_rvalid = rd_valid && rd_host;
        cpu_rdata   = cpu_rvalid  ? mem_entry_out : '0;
        host_rdata  = host_rvalid ? mem_entry_out : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed vectors, expected load
// responses queued at issue and checked by a separate monitor.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_wr_en;
    logic [AW-1:0] mem_index;
    logic [DW-1:0] mem_entry;
    logic [DW-1:0] mem_entry_out;
    logic [3:0]    starve_cnt;

    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(4)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_wr_en(mem_wr_en), .mem_index(mem_index),
        .mem_entry(mem_entry), .mem_entry_out(mem_entry_out),
        .starve_cnt(starve_cnt)
    );

    // Synchronous RAM: read data one cycle after address, preload port for setup.
    always_ff @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (mem_wr_en) ram[mem_index] <= mem_entry;
        mem_entry_out <= ram[mem_index];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        host_req = 1'b0;
        host_we  = 1'b0;
    endtask

    task automatic push(input logic port, input logic [DW-1:0] d);
        exp_t e;
        e.port = port;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every rvalid pops one expected response and compares it.
    always @(negedge clk) begin
        exp_t          e;
        logic          gport;
        logic [DW-1:0] got, oth;
        if (cpu_rvalid || host_rvalid) begin
            n_cmp++;
            gport = host_rvalid;
            got   = host_rvalid ? host_rdata : cpu_rdata;
            oth   = host_rvalid ? cpu_rdata : host_rdata;
            if (cpu_rvalid && host_rvalid) begin
                n_err++;
                $display("FAIL both_rvalid: got cpu=1 host=1 want one");
            end else if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rvalid: got port=%0d data=%0h want none",
                         gport, got);
            end else begin
                e = exp_q.pop_front();
                if (gport !== e.port || got !== e.data || oth !== '0) begin
                    n_err++;
                    $display("FAIL rdata: got port=%0d data=%0h other=%0h want port=%0d data=%0h other=0",
                             gport, got, oth, e.port, e.data);
                end
            end
        end
    end

    initial begin
        rstn = 1'b0;
        idle();
        cpu_addr = '0; cpu_wdata = '0;
        host_addr = '0; host_wdata = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        tick();

        // Preload RAM contents while held in reset.
        pl_we = 1'b1; pl_addr = 10'd5; pl_data = 32'hDEAD_BEEF; tick();
        pl_addr = 10'd1; pl_data = 32'h1111_1111; tick();
        pl_addr = 10'd2; pl_data = 32'h2222_2222; tick();
        pl_addr = 10'd9; pl_data = 32'h0000_0099; tick();
        pl_we = 1'b0;

        // Reset: grants still combinational, writes suppressed.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd9; cpu_wdata = 32'hFFFF;
        @(negedge clk);
        chk("rst_starve", 32'(starve_cnt), 0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("rst_cpu_gnt", 32'(cpu_gnt), 1);
        chk("rst_wr_en", 32'(mem_wr_en), 0);
        tick();
        rstn = 1'b1;
        idle();
        @(negedge clk);
        chk("post_rst_host_rvalid", 32'(host_rvalid), 0);
        tick();

        // Store attempted in reset must not have landed.
        cpu_req = 1'b1; cpu_addr = 10'd9;
        @(negedge clk);
        push(1'b0, 32'h0000_0099);
        tick();

        // CPU-only load.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
        @(negedge clk);
        chk("c1_cpu_gnt", 32'(cpu_gnt), 1);
        chk("c1_host_gnt", 32'(host_gnt), 0);
        chk("c1_index", 32'(mem_index), 5);
        chk("c1_wr_en", 32'(mem_wr_en), 0);
        push(1'b0, 32'hDEAD_BEEF);
        tick();

        // Host-only store, then CPU load of it.
        idle();
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'd3; host_wdata = 32'h1234;
        @(negedge clk);
        chk("h_st_host_gnt", 32'(host_gnt), 1);
        chk("h_st_wr_en", 32'(mem_wr_en), 1);
        chk("h_st_index", 32'(mem_index), 3);
        chk("h_st_entry", mem_entry, 32'h1234);
        tick();
        idle();
        cpu_req = 1'b1; cpu_addr = 10'd3;
        @(negedge clk);
        push(1'b0, 32'h1234);
        tick();

        // CPU store then CPU load of the same address back to back.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd7; cpu_wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        chk("c_st_entry", mem_entry, 32'hA5A5_5A5A);
        tick();
        cpu_we = 1'b0;
        @(negedge clk);
        push(1'b0, 32'hA5A5_5A5A);
        tick();

        // Starvation: both ports loading every cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'd2;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk($sformatf("sv_starve_%0d", k), 32'(starve_cnt), (k - 1) % 5);
            chk($sformatf("sv_host_gnt_%0d", k), 32'(host_gnt),
                (k % 5 == 0) ? 1 : 0);
            chk($sformatf("sv_cpu_gnt_%0d", k), 32'(cpu_gnt),
                (k % 5 == 0) ? 0 : 1);
            if (k % 5 == 0) push(1'b1, 32'h2222_2222);
            else push(1'b0, 32'h1111_1111);
            tick();
        end

        // Host withdraws after three ungranted cycles.
        cpu_addr = 10'd5;
        for (int k = 1; k <= 5; k++) begin
            host_req = (k <= 3);
            @(negedge clk);
            chk($sformatf("wd_starve_%0d", k), 32'(starve_cnt),
                (k <= 4) ? k - 1 : 0);
            chk($sformatf("wd_host_gnt_%0d", k), 32'(host_gnt), 0);
            push(1'b0, 32'hDEAD_BEEF);
            tick();
        end

        // Reset mid-load drops the pending response.
        cpu_req = 1'b1; cpu_addr = 10'd5; host_req = 1'b1;
        @(negedge clk);
        push(1'b0, 32'hDEAD_BEEF);
        tick();
        rstn = 1'b0;
        @(negedge clk);
        chk("rl_starve_pre", 32'(starve_cnt), 1);
        chk("rl_cpu_gnt", 32'(cpu_gnt), 1);
        tick();
        cpu_we = 1'b1; cpu_wdata = 32'h0BAD;
        @(negedge clk);
        chk("rl_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("rl_starve", 32'(starve_cnt), 0);
        chk("rl_wr_en", 32'(mem_wr_en), 0);
        tick();
        rstn = 1'b1;
        idle();
        @(negedge clk);
        chk("rl_cpu_rvalid2", 32'(cpu_rvalid), 0);
        tick();
        cpu_req = 1'b1; cpu_addr = 10'd5;
        @(negedge clk);
        push(1'b0, 32'hDEAD_BEEF);
        tick();

        idle();
        tick();
        tick();
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
